// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-through, no-write-allocate cache
// with an integrated miss-fill FSM, round-robin replacement and a one-set-per-
// cycle flush. Owns the handshake towards the multi-cycle main memory.
module assoc_cache #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int WORDS      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_flush,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  busy,
    output logic                  miss_detected,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    input  logic                  mem_ack
);

    // Byte offset covers 2 bytes per word; bit 0 of the address is ignored.
    localparam int OFF_W  = $clog2(2 * WORDS);
    localparam int WORD_W = OFF_W - 1;
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - SET_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
    localparam logic [SET_W-1:0]  LAST_SET  = SET_W'(SETS - 1);
    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TAG   = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    // Control / output registers
    logic [2:0]            state_q,   state_d;
    logic [WORD_W-1:0]     cnt_q,     cnt_d;
    logic [WAY_W-1:0]      victim_q,  victim_d;
    logic                  useptr_q,  useptr_d;
    logic [SET_W-1:0]      fset_q,    fset_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  done_q,    done_d;
    logic                  busy_q,    busy_d;
    logic                  miss_q,    miss_d;
    logic                  mreq_q,    mreq_d;
    logic                  mwe_q,     mwe_d;
    logic [ADDR_WIDTH-1:0] maddr_q,   maddr_d;
    logic [DATA_WIDTH-1:0] mwdata_q,  mwdata_d;

    // Captured request (data path, not reset)
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic                  we_q,      we_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;

    // Arrays: valid bits and pointers are reset, tags and data are not
    logic                  valid_q [SETS][WAYS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [WAY_W-1:0]      ptr_q   [SETS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][WORDS];

    // Request decode
    logic [TAG_W-1:0]  req_tag;
    logic [SET_W-1:0]  req_set;
    logic [WORD_W-1:0] req_word;

    assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign req_set  = addr_q[OFF_W +: SET_W];
    assign req_word = addr_q[1 +: WORD_W];

    // Lookup results
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [DATA_WIDTH-1:0] hit_word;
    logic [WAY_W-1:0]      vic_way;
    logic                  vic_useptr;
    logic [WAY_W-1:0]      cur_ptr;
    logic [WAY_W-1:0]      ptr_next;

    // Array write controls
    logic                  dwe;
    logic [WAY_W-1:0]      dway;
    logic [WORD_W-1:0]     dword;
    logic [DATA_WIDTH-1:0] dval;
    logic                  fill_done;
    logic                  flush_clr;

    // Tag compare and victim choice for the indexed set (lowest invalid way first)
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        cur_ptr    = ptr_q[req_set];
        vic_way    = cur_ptr;
        vic_useptr = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) begin
                vic_way    = WAY_W'(w);
                vic_useptr = 1'b0;
            end
        end
        ptr_next = (cur_ptr == LAST_WAY) ? '0 : cur_ptr + WAY_W'(1);
        hit_word = data_q[req_set][hit_way][req_word];
    end

    // Next-state logic of the controller FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        victim_d  = victim_q;
        useptr_d  = useptr_q;
        fset_d    = fset_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        miss_d    = miss_q;
        mreq_d    = mreq_q;
        mwe_d     = mwe_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        dwe       = 1'b0;
        dway      = hit_way;
        dword     = req_word;
        dval      = wdata_q;
        fill_done = 1'b0;
        flush_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_flush) begin
                    state_d = S_FLUSH;
                    busy_d  = 1'b1;
                    fset_d  = '0;
                end else if (cpu_req && !done_q) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = S_TAG;
                    busy_d  = 1'b1;
                end
            end
            S_TAG: begin
                if (we_q) begin
                    // Write-through: update only a hitting way, never allocate
                    dwe      = hit;
                    state_d  = S_WRITE;
                    mreq_d   = 1'b1;
                    mwe_d    = 1'b1;
                    maddr_d  = addr_q;
                    mwdata_d = wdata_q;
                end else if (hit) begin
                    rdata_d = hit_word;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_FILL;
                    mreq_d   = 1'b1;
                    mwe_d    = 1'b0;
                    maddr_d  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    miss_d   = 1'b1;
                    cnt_d    = '0;
                    victim_d = vic_way;
                    useptr_d = vic_useptr;
                end
            end
            S_FILL: begin
                if (mem_rvalid) begin
                    dwe   = 1'b1;
                    dway  = victim_q;
                    dword = cnt_q;
                    dval  = mem_rdata;
                    cnt_d = cnt_q + WORD_W'(1);
                    if (cnt_q == req_word) begin
                        rdata_d = mem_rdata;
                    end
                    // Valid/tag only on the last word so a partial fill never hits
                    if (cnt_q == LAST_WORD) begin
                        fill_done = 1'b1;
                        cnt_d     = '0;
                        mreq_d    = 1'b0;
                        miss_d    = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                flush_clr = 1'b1;
                fset_d    = fset_q + SET_W'(1);
                if (fset_q == LAST_SET) begin
                    fset_d  = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                mreq_d  = 1'b0;
                mwe_d   = 1'b0;
                miss_d  = 1'b0;
            end
        endcase
    end

    // Controller registers; reset abandons any fill or write in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            victim_q <= '0;
            useptr_q <= 1'b0;
            fset_q   <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            miss_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            useptr_q <= useptr_d;
            fset_q   <= fset_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            miss_q   <= miss_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    // Captured request fields; only meaningful after an accept
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    // Valid bits and round-robin pointers: set on fill completion, cleared by flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else begin
            if (fill_done) begin
                valid_q[req_set][victim_q] <= 1'b1;
                if (useptr_q) begin
                    ptr_q[req_set] <= ptr_next;
                end
            end
            if (flush_clr) begin
                ptr_q[fset_q] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[fset_q][w] <= 1'b0;
                end
            end
        end
    end

    // Tag and data storage, written by fills and write hits
    always_ff @(posedge clk) begin
        if (dwe) begin
            data_q[req_set][dway][dword] <= dval;
        end
        if (fill_done) begin
            tag_q[req_set][victim_q] <= req_tag;
        end
    end

    assign cpu_rdata     = rdata_q;
    assign cpu_done      = done_q;
    assign busy          = busy_q;
    assign miss_detected = miss_q;
    assign mem_req       = mreq_q;
    assign mem_we        = mwe_q;
    assign mem_addr      = maddr_q;
    assign mem_wdata     = mwdata_q;

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed bench for assoc_cache. Instance 0 uses WAYS=2,
// instance 1 uses WAYS=4; both share the clock but have separate stimulus.
module tb_assoc_cache;

    logic        clk;
    logic        rst_n   [2];
    logic        req     [2];
    logic        we      [2];
    logic [15:0] addr    [2];
    logic [15:0] wdata   [2];
    logic        flush   [2];
    logic [15:0] mrdata  [2];
    logic        mrvalid [2];
    logic        mack    [2];
    logic [15:0] rdata   [2];
    logic        done    [2];
    logic        busy    [2];
    logic        miss    [2];
    logic        mreq    [2];
    logic        mwe     [2];
    logic [15:0] maddr   [2];
    logic [15:0] mwdata  [2];

    int total = 0;
    int bad   = 0;

    assoc_cache #(.WAYS(2)) u_a (
        .clk(clk), .rst(rst_n[0]), .cpu_req(req[0]), .cpu_we(we[0]),
        .cpu_addr(addr[0]), .cpu_wdata(wdata[0]), .cpu_flush(flush[0]),
        .cpu_rdata(rdata[0]), .cpu_done(done[0]), .busy(busy[0]),
        .miss_detected(miss[0]), .mem_req(mreq[0]), .mem_we(mwe[0]),
        .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]),
        .mem_rvalid(mrvalid[0]), .mem_ack(mack[0])
    );

    assoc_cache #(.WAYS(4)) u_b (
        .clk(clk), .rst(rst_n[1]), .cpu_req(req[1]), .cpu_we(we[1]),
        .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_flush(flush[1]),
        .cpu_rdata(rdata[1]), .cpu_done(done[1]), .busy(busy[1]),
        .miss_detected(miss[1]), .mem_req(mreq[1]), .mem_we(mwe[1]),
        .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]),
        .mem_rvalid(mrvalid[1]), .mem_ack(mack[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle request; leaves the bench on the negedge after the accept edge
    task automatic issue(input int s, input logic w, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
        @(negedge clk);
        req[s] = 1'b0;
    endtask

    // Called on the negedge after the TAG edge of a read miss
    task automatic fill(input int s, input logic [15:0] a, input logic [15:0] base,
                        input int gap, input string tag);
        chk({tag, "_req"}, {29'd0, mreq[s], mwe[s], miss[s]}, 32'h5);
        chk({tag, "_maddr"}, {16'd0, maddr[s]}, {16'd0, a & 16'hFFF0});
        for (int i = 0; i < 8; i++) begin
            mrvalid[s] = 1'b1;
            mrdata[s]  = base + 16'(i);
            @(negedge clk);
            mrvalid[s] = 1'b0;
            mrdata[s]  = 16'hXXXX;
            if (i < 7) repeat (gap) @(negedge clk);
        end
        chk({tag, "_done"}, {29'd0, done[s], mreq[s], miss[s]}, 32'h4);
        chk({tag, "_data"}, {16'd0, rdata[s]}, {16'd0, base + 16'((a >> 1) & 16'h7)});
    endtask

    task automatic read_miss(input int s, input logic [15:0] a, input logic [15:0] base,
                             input int gap, input string tag);
        issue(s, 1'b0, a, 16'h0);
        @(negedge clk);
        fill(s, a, base, gap, tag);
    endtask

    task automatic read_hit(input int s, input logic [15:0] a, input logic [15:0] exp,
                            input string tag);
        issue(s, 1'b0, a, 16'h0);
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, done[s], mreq[s]}, 32'h2);
        chk({tag, "_data"}, {16'd0, rdata[s]}, {16'd0, exp});
    endtask

    task automatic write(input int s, input logic [15:0] a, input logic [15:0] d,
                         input int ack_delay, input string tag);
        issue(s, 1'b1, a, d);
        @(negedge clk);
        chk({tag, "_req"}, {30'd0, mreq[s], mwe[s]}, 32'h3);
        chk({tag, "_maddr"}, {16'd0, maddr[s]}, {16'd0, a});
        chk({tag, "_mwdata"}, {16'd0, mwdata[s]}, {16'd0, d});
        repeat (ack_delay) @(negedge clk);
        mack[s] = 1'b1;
        @(negedge clk);
        mack[s] = 1'b0;
        chk({tag, "_done"}, {29'd0, done[s], mreq[s], mwe[s]}, 32'h4);
    endtask

    initial begin
        int  bcnt;
        logic saw_mreq;
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0; req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0;
            wdata[s] = '0; flush[s] = 1'b0; mrdata[s] = '0; mrvalid[s] = 1'b0;
            mack[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_ctrl", {27'd0, done[s], busy[s], miss[s], mreq[s], mwe[s]}, 32'h0);
            chk("reset_data", {rdata[s], maddr[s] | mwdata[s]}, 32'h0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Read miss with gaps between fill words, then a 2-cycle hit
        read_miss(0, 16'h1234, 16'h1000, 2, "miss1234");
        read_hit(0, 16'h1234, 16'h1002, "hit1234");

        // Write hit: write-through, then the cached copy reflects it
        write(0, 16'h1236, 16'hBEEF, 2, "whit");
        read_hit(0, 16'h1236, 16'hBEEF, "hit1236");
        read_hit(0, 16'h1234, 16'h1002, "hit1234b");

        // Round-robin replacement in set 0 with two ways
        read_miss(0, 16'h0000, 16'h7000, 0, "r0000");
        read_miss(0, 16'h0400, 16'h7400, 0, "r0400");
        read_miss(0, 16'h0800, 16'h7800, 1, "r0800");
        read_hit(0, 16'h0400, 16'h7400, "h0400");
        read_miss(0, 16'h0000, 16'h7100, 0, "r0000b");
        read_miss(0, 16'h0400, 16'h7500, 0, "r0400b");
        read_hit(0, 16'h0000, 16'h7100, "h0000");

        // Write miss allocates nothing
        write(0, 16'h4000, 16'h5555, 0, "wmiss");
        read_miss(0, 16'h4000, 16'h4000, 0, "r4000");

        // Flush wins over a simultaneous request; request is taken afterwards
        @(negedge clk);
        flush[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h1234;
        @(negedge clk);
        flush[0] = 1'b0;
        bcnt = 0;
        saw_mreq = 1'b0;
        while (busy[0] && bcnt < 200) begin
            bcnt++;
            if (mreq[0] || miss[0] || done[0]) saw_mreq = 1'b1;
            @(negedge clk);
        end
        chk("flush_cycles", bcnt, 64);
        chk("flush_quiet", {31'd0, saw_mreq}, 32'h0);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        fill(0, 16'h1234, 16'h3000, 0, "flush_refill");

        // WAYS=4: reset in the middle of a fill abandons it
        issue(1, 1'b0, 16'h1234, 16'h0);
        @(negedge clk);
        chk("b_fill_req", {31'd0, mreq[1]}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            mrvalid[1] = 1'b1;
            mrdata[1]  = 16'hDE00 + 16'(i);
            @(negedge clk);
        end
        mrvalid[1] = 1'b0;
        rst_n[1] = 1'b0;
        #1;
        chk("b_rst_drop", {29'd0, mreq[1], busy[1], miss[1]}, 32'h0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        read_miss(1, 16'h1234, 16'h2000, 1, "b_refill");
        read_hit(1, 16'h1230, 16'h2000, "b_hw0");
        read_hit(1, 16'h123E, 16'h2007, "b_hw7");

        // WAYS=4 round-robin in set 0
        read_miss(1, 16'h0000, 16'h6000, 0, "b_r0000");
        read_miss(1, 16'h0400, 16'h6400, 0, "b_r0400");
        read_miss(1, 16'h0800, 16'h6800, 0, "b_r0800");
        read_miss(1, 16'h0C00, 16'h6C00, 0, "b_r0C00");
        read_miss(1, 16'h1000, 16'h6100, 0, "b_r1000");
        read_hit(1, 16'h0400, 16'h6400, "b_h0400");
        read_miss(1, 16'h0000, 16'h6010, 0, "b_r0000b");
        read_hit(1, 16'h0800, 16'h6800, "b_h0800");
        read_hit(1, 16'h1000, 16'h6100, "b_h1000");
        read_miss(1, 16'h0400, 16'h6410, 0, "b_r0400b");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
